// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//
// Purpose:
//   Bitwise half adder with WIDTH independent lanes. There is no carry
//   between lanes. For each lane i: S[i] = A[i] ^ B[i] and C[i] = A[i] & B[i].
//   S and C are combinational outputs. S_q and C_q are registered copies
//   with a one-cycle latency, qualified by out_valid.
//
// Optional feature (macro HALF_ADDER_STATS_EN):
//   When the macro is defined, the module adds a carry_cnt port and a
//   saturating counter. The counter counts captures in which any lane
//   produced a carry. When the macro is undefined, the port and the
//   counter are absent.
//
// Parameters:
//   WIDTH  number of independent lanes (>= 1)
//   CNT_W  width of the carry-event counter
//
// Ports:
//   S         out WIDTH  combinational sum, A ^ B
//   C         out WIDTH  combinational carry, A & B
//   A, B      in  WIDTH  operands
//   clk       in  1      rising-edge clock for the registered path
//   rst       in  1      asynchronous reset, active-high
//   in_valid  in  1      capture A/B results on the next rising edge
//   S_q, C_q  out WIDTH  registered sum / carry
//   out_valid out 1      S_q/C_q were captured on the most recent edge
//   carry_cnt out CNT_W  saturating carry-event count (stats build only)
// ---------------------------------------------------------------------------
module half_adder #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S_q,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  // Combinational lanes: these do not depend on clk, rst or in_valid.
  assign S = A ^ B;
  assign C = A & B;

  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] c_d;
  logic             vld_d;

  always_comb begin
    s_d   = S_q;
    c_d   = C_q;
    vld_d = in_valid;
    if (in_valid) begin
      s_d = S;
      c_d = C;
    end
  end

  // Registered stage: capture on in_valid; otherwise hold the data and
  // drop the valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S_q       <= '0;
      C_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      S_q       <= s_d;
      C_q       <= c_d;
      out_valid <= vld_d;
    end
  end

`ifdef HALF_ADDER_STATS_EN
  // Increment by one, but stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) sat_inc = v;
    else    sat_inc = v + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (in_valid && (|C)) cnt_d = sat_inc(cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign carry_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

  logic       clk;
  logic       rst;
  logic [3:0] a4, b4;
  logic [3:0] s4, c4, sq4, cq4;
  logic       iv4, ov4;
  logic       a1, b1, s1, c1, sq1, cq1, iv1, ov1;
  int         checks;
  int         errors;
`ifdef HALF_ADDER_STATS_EN
  logic [1:0]  cnt4;
  logic [15:0] cnt1;
`endif

  half_adder #(.WIDTH(4), .CNT_W(2)) dut4 (
    .S(s4), .C(c4), .A(a4), .B(b4), .clk(clk), .rst(rst),
    .in_valid(iv4), .S_q(sq4), .C_q(cq4), .out_valid(ov4)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(cnt4)
`endif
  );

  half_adder #(.WIDTH(1), .CNT_W(16)) dut1 (
    .S(s1), .C(c1), .A(a1), .B(b1), .clk(clk), .rst(rst),
    .in_valid(iv1), .S_q(sq1), .C_q(cq1), .out_valid(ov1)
`ifdef HALF_ADDER_STATS_EN
    , .carry_cnt(cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    iv4 = 1'b0; iv1 = 1'b0;
    a4 = 4'h0; b4 = 4'h0; a1 = 1'b0; b1 = 1'b0;

    // Asynchronous reset, before any clock edge.
    #3;
    check("rst_sq", 32'(sq4), 32'h0);
    check("rst_cq", 32'(cq4), 32'h0);
    check("rst_ov", 32'(ov4), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1-bit combinational sequence with no clock dependence.
    a1 = 1'b0; b1 = 1'b0; #1;
    check("seq00", 32'({c1, s1}), 32'h0);
    a1 = 1'b1; #1;
    check("seq10", 32'({c1, s1}), 32'h1);
    b1 = 1'b1; #1;
    check("seq11", 32'({c1, s1}), 32'h2);
    a1 = 1'b0; #1;
    check("seq01", 32'({c1, s1}), 32'h1);

    // WIDTH=4 capture.
    @(negedge clk);
    a4 = 4'b1100; b4 = 4'b1010; iv4 = 1'b1; #1;
    check("comb_s4", 32'(s4), 32'h6);
    check("comb_c4", 32'(c4), 32'h8);
    @(posedge clk); #1;
    check("cap_sq4", 32'(sq4), 32'h6);
    check("cap_cq4", 32'(cq4), 32'h8);
    check("cap_ov4", 32'(ov4), 32'h1);

    // Hold while in_valid=0 and operands toggle.
    @(negedge clk);
    iv4 = 1'b0; a4 = 4'b0011; b4 = 4'b0101; #1;
    check("hold_comb_s4", 32'(s4), 32'h6);
    check("hold_comb_c4", 32'(c4), 32'h1);
    @(posedge clk); #1;
    check("hold_sq4", 32'(sq4), 32'h6);
    check("hold_cq4", 32'(cq4), 32'h8);
    check("hold_ov4", 32'(ov4), 32'h0);
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b1111;
    @(posedge clk); #1;
    check("hold2_sq4", 32'(sq4), 32'h6);
    check("hold2_cq4", 32'(cq4), 32'h8);

    // Capture a fresh value, then reset between edges.
    @(negedge clk);
    a4 = 4'b1111; b4 = 4'b0000; iv4 = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_sq4", 32'(sq4), 32'hF);
    check("pre_rst_ov4", 32'(ov4), 32'h1);
    #2;
    rst = 1'b1; #1;
    check("mid_rst_sq4", 32'(sq4), 32'h0);
    check("mid_rst_cq4", 32'(cq4), 32'h0);
    check("mid_rst_ov4", 32'(ov4), 32'h0);
    // An edge while reset is held must not capture.
    @(negedge clk);
    a4 = 4'b0001; b4 = 4'b0001;
    @(posedge clk); #1;
    check("rst_held_cq4", 32'(cq4), 32'h0);
    check("rst_held_ov4", 32'(ov4), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_sq4", 32'(sq4), 32'h0);
    check("post_rst_cq4", 32'(cq4), 32'h1);
    check("post_rst_ov4", 32'(ov4), 32'h1);

`ifdef HALF_ADDER_STATS_EN
    // Saturating 2-bit carry counter.
    @(negedge clk);
    rst = 1'b1; #1;
    check("cnt_rst", 32'(cnt4), 32'h0);
    rst = 1'b0;
    a4 = 4'b0001; b4 = 4'b0001; iv4 = 1'b1;
    @(posedge clk); #1; check("cnt_c1", 32'(cnt4), 32'h1);
    @(posedge clk); #1; check("cnt_c2", 32'(cnt4), 32'h2);
    @(posedge clk); #1; check("cnt_c3", 32'(cnt4), 32'h3);
    @(posedge clk); #1; check("cnt_c4", 32'(cnt4), 32'h3);
    @(posedge clk); #1; check("cnt_c5", 32'(cnt4), 32'h3);
    @(negedge clk);
    iv4 = 1'b0;
`endif

    // Exhaustive 1-bit sweep with hand-computed {C,S} = A + B.
    a1 = 1'b0; b1 = 1'b0; #1; check("sweep00", 32'({c1, s1}), 32'h0);
    a1 = 1'b0; b1 = 1'b1; #1; check("sweep01", 32'({c1, s1}), 32'h1);
    a1 = 1'b1; b1 = 1'b0; #1; check("sweep10", 32'({c1, s1}), 32'h1);
    a1 = 1'b1; b1 = 1'b1; #1; check("sweep11", 32'({c1, s1}), 32'h2);

    // 1-bit registered path for the carry case.
    @(negedge clk);
    iv1 = 1'b1;
    @(posedge clk); #1;
    check("w1_cq", 32'({cq1, sq1, ov1}), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
